// File: rtl/cacheline_adapter_pkg.sv
// rtl/cacheline_adapter_pkg.sv - shared constants, state type and helpers for the cacheline adapter
package cacheline_adapter_pkg;

    localparam int BEAT_W    = 64;
    localparam int BURST_LEN = 4;
    localparam int LINE_W    = BURST_LEN * BEAT_W;
    localparam int LINE_OFS  = 5;
    localparam int CNT_W     = $clog2(BURST_LEN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_CMD,
        S_RD_DATA,
        S_WR_DATA,
        S_RESP
    } adapter_state_t;

    function automatic logic [31:0] line_align(input logic [31:0] addr);
        return {addr[31:LINE_OFS], {LINE_OFS{1'b0}}};
    endfunction

endpackage

// File: rtl/cacheline_adapter_d_deser.sv
// rtl/cacheline_adapter_d_deser.sv - indexed beat-to-line assembler for the read path
module burst_deserializer
    import cacheline_adapter_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              beat_valid,
    input  logic [BEAT_W-1:0] beat_data,
    output logic [LINE_W-1:0] line,
    output logic              done
);

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [LINE_W-1:0] line_q, line_d;

    // clear only rewinds the index; the line keeps its last contents
    always_comb begin
        cnt_d  = cnt_q;
        line_d = line_q;
        done   = 1'b0;
        if (clear) begin
            cnt_d = '0;
        end else if (beat_valid) begin
            line_d[cnt_q*BEAT_W +: BEAT_W] = beat_data;
            cnt_d = cnt_q + 1'b1;
            done  = (cnt_q == CNT_W'(BURST_LEN-1));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            line_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            line_q <= line_d;
        end
    end

    assign line = line_q;

endmodule

// File: rtl/cacheline_adapter_d.sv
// rtl/cacheline_adapter_d.sv - 256-bit line request to 4x64-bit DRAM burst adapter
module cacheline_adapter_d
    import cacheline_adapter_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       mem_addr,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [LINE_W-1:0] mem_wdata,
    output logic [LINE_W-1:0] mem_rdata,
    output logic              mem_resp,
    output logic [31:0]       mem_raddr,
    output logic [31:0]       bmem_addr,
    output logic              bmem_read,
    output logic              bmem_write,
    output logic [BEAT_W-1:0] bmem_wdata,
    input  logic              bmem_ready,
    input  logic [31:0]       bmem_raddr,
    input  logic [BEAT_W-1:0] bmem_rdata,
    input  logic              bmem_rvalid,
    output logic [31:0]       stat_read_lines,
    output logic [31:0]       stat_write_lines,
    output logic [31:0]       stat_stall_cycles
);

    adapter_state_t    state_q, state_d;
    logic [31:0]       addr_q, addr_d;
    logic [LINE_W-1:0] wbuf_q, wbuf_d;
    logic [CNT_W-1:0]  wcnt_q, wcnt_d;
    logic              is_wr_q, is_wr_d;
    logic [31:0]       rd_lines_q, rd_lines_d;
    logic [31:0]       wr_lines_q, wr_lines_d;
    logic [31:0]       stall_q, stall_d;

    logic              beat_ok;
    logic              rd_clear;
    logic              rd_done;
    logic [LINE_W-1:0] rd_line;

    // beats tagged for another line are dropped without advancing the index
    assign beat_ok = (state_q == S_RD_DATA) && bmem_rvalid &&
                     (bmem_raddr[31:LINE_OFS] == addr_q[31:LINE_OFS]);

    burst_deserializer u_deser (
        .clk        (clk),
        .rst        (rst),
        .clear      (rd_clear),
        .beat_valid (beat_ok),
        .beat_data  (bmem_rdata),
        .line       (rd_line),
        .done       (rd_done)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wbuf_d     = wbuf_q;
        wcnt_d     = wcnt_q;
        is_wr_d    = is_wr_q;
        rd_lines_d = rd_lines_q;
        wr_lines_d = wr_lines_q;
        stall_d    = stall_q;
        rd_clear   = 1'b0;
        bmem_read  = 1'b0;
        bmem_write = 1'b0;
        bmem_addr  = '0;
        bmem_wdata = '0;
        mem_resp   = 1'b0;
        mem_raddr  = '0;
        mem_rdata  = '0;
        unique case (state_q)
            S_IDLE: begin
                rd_clear = 1'b1;
                if (mem_write) begin
                    addr_d  = line_align(mem_addr);
                    wbuf_d  = mem_wdata;
                    wcnt_d  = '0;
                    is_wr_d = 1'b1;
                    state_d = S_WR_DATA;
                end else if (mem_read) begin
                    addr_d  = line_align(mem_addr);
                    is_wr_d = 1'b0;
                    state_d = S_RD_CMD;
                end
            end
            S_RD_CMD: begin
                bmem_read = 1'b1;
                bmem_addr = addr_q;
                if (bmem_ready) state_d = S_RD_DATA;
                else            stall_d = stall_q + 32'd1;
            end
            S_RD_DATA: begin
                if (rd_done) state_d = S_RESP;
            end
            S_WR_DATA: begin
                bmem_write = 1'b1;
                bmem_addr  = addr_q;
                bmem_wdata = wbuf_q[wcnt_q*BEAT_W +: BEAT_W];
                if (bmem_ready) begin
                    wcnt_d = wcnt_q + 1'b1;
                    if (wcnt_q == CNT_W'(BURST_LEN-1)) state_d = S_RESP;
                end else begin
                    stall_d = stall_q + 32'd1;
                end
            end
            S_RESP: begin
                mem_resp  = 1'b1;
                mem_raddr = addr_q;
                mem_rdata = rd_line;
                if (is_wr_q) wr_lines_d = wr_lines_q + 32'd1;
                else         rd_lines_d = rd_lines_q + 32'd1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            wbuf_q     <= '0;
            wcnt_q     <= '0;
            is_wr_q    <= 1'b0;
            rd_lines_q <= '0;
            wr_lines_q <= '0;
            stall_q    <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wbuf_q     <= wbuf_d;
            wcnt_q     <= wcnt_d;
            is_wr_q    <= is_wr_d;
            rd_lines_q <= rd_lines_d;
            wr_lines_q <= wr_lines_d;
            stall_q    <= stall_d;
        end
    end

    assign stat_read_lines   = rd_lines_q;
    assign stat_write_lines  = wr_lines_q;
    assign stat_stall_cycles = stall_q;

endmodule

// File: tb/tb_cacheline_adapter_d.sv
// tb/tb_cacheline_adapter_d.sv - scoreboard bench for cacheline_adapter_d
module tb_cacheline_adapter_d;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  mem_addr;
    logic         mem_read, mem_write;
    logic [255:0] mem_wdata, mem_rdata;
    logic         mem_resp;
    logic [31:0]  mem_raddr, bmem_addr;
    logic         bmem_read, bmem_write;
    logic [63:0]  bmem_wdata;
    logic         bmem_ready;
    logic [31:0]  bmem_raddr;
    logic [63:0]  bmem_rdata;
    logic         bmem_rvalid;
    logic [31:0]  stat_read_lines, stat_write_lines, stat_stall_cycles;

    cacheline_adapter_d dut (
        .clk               (clk),
        .rst               (rst),
        .mem_addr          (mem_addr),
        .mem_read          (mem_read),
        .mem_write         (mem_write),
        .mem_wdata         (mem_wdata),
        .mem_rdata         (mem_rdata),
        .mem_resp          (mem_resp),
        .mem_raddr         (mem_raddr),
        .bmem_addr         (bmem_addr),
        .bmem_read         (bmem_read),
        .bmem_write        (bmem_write),
        .bmem_wdata        (bmem_wdata),
        .bmem_ready        (bmem_ready),
        .bmem_raddr        (bmem_raddr),
        .bmem_rdata        (bmem_rdata),
        .bmem_rvalid       (bmem_rvalid),
        .stat_read_lines   (stat_read_lines),
        .stat_write_lines  (stat_write_lines),
        .stat_stall_cycles (stat_stall_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [255:0] data;
        logic [31:0]  addr;
        logic         is_read;
    } resp_t;

    typedef struct {
        logic [31:0] addr;
        logic [63:0] data;
    } wbeat_t;

    resp_t       resp_q[$];
    logic [31:0] cmd_q[$];
    wbeat_t      wb_q[$];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s act=event exp=none", name);
    endtask

    // Monitor: compares every DUT-presented event against the scoreboard queues
    always @(negedge clk) begin
        if (mem_resp) begin
            if (resp_q.size() == 0) fail_now("resp_unexpected");
            else begin
                resp_t r;
                r = resp_q.pop_front();
                check("resp_raddr", {224'd0, mem_raddr}, {224'd0, r.addr});
                if (r.is_read) check("resp_rdata", mem_rdata, r.data);
            end
        end
        if (bmem_read && bmem_ready) begin
            if (cmd_q.size() == 0) fail_now("rd_cmd_unexpected");
            else check("rd_cmd_addr", {224'd0, bmem_addr}, {224'd0, cmd_q.pop_front()});
        end
        if (bmem_write && bmem_ready) begin
            if (wb_q.size() == 0) fail_now("wr_beat_unexpected");
            else begin
                wbeat_t w;
                w = wb_q.pop_front();
                check("wr_beat_addr", {224'd0, bmem_addr}, {224'd0, w.addr});
                check("wr_beat_data", {192'd0, bmem_wdata}, {192'd0, w.data});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [31:0] a, input logic [63:0] d);
        bmem_rvalid = 1'b1;
        bmem_raddr  = a;
        bmem_rdata  = d;
        tick();
        bmem_rvalid = 1'b0;
        bmem_raddr  = '0;
        bmem_rdata  = '0;
    endtask

    // Waits up to max cycle-starts for mem_resp, then drops the request
    task automatic wait_resp(input string name, input int max);
        bit seen = 0;
        for (int i = 0; i < max; i++) begin
            if (mem_resp) begin
                seen = 1;
                break;
            end
            tick();
        end
        check(name, {255'd0, seen}, 256'd1);
        mem_read  = 1'b0;
        mem_write = 1'b0;
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic push_read(input logic [31:0] line, input logic [255:0] data);
        resp_t r;
        cmd_q.push_back(line);
        r.data = data; r.addr = line; r.is_read = 1'b1;
        resp_q.push_back(r);
    endtask

    task automatic push_write(input logic [31:0] line, input logic [255:0] data);
        resp_t  r;
        wbeat_t w;
        for (int k = 0; k < 4; k++) begin
            w.addr = line;
            w.data = data[k*64 +: 64];
            wb_q.push_back(w);
        end
        r.data = '0; r.addr = line; r.is_read = 1'b0;
        resp_q.push_back(r);
    endtask

    logic [255:0] line_a, line_w, line_c, line_d, line_e, line_f;

    initial begin
        rst = 1'b1; mem_addr = '0; mem_read = 1'b0; mem_write = 1'b0; mem_wdata = '0;
        bmem_ready = 1'b1; bmem_raddr = '0; bmem_rdata = '0; bmem_rvalid = 1'b0;
        line_a = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                  64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        line_w = {64'hDDDD_0000_0000_000D, 64'hCCCC_0000_0000_000C,
                  64'hBBBB_0000_0000_000B, 64'hAAAA_0000_0000_000A};
        line_c = {64'hC3, 64'hC2, 64'hC1, 64'hC0};
        line_d = {64'hD3, 64'hD2, 64'hD1, 64'hD0};
        line_e = {64'hE3, 64'hE2, 64'hE1, 64'hE0};
        line_f = {64'hF3, 64'hF2, 64'hF1, 64'hF0};
        tick();
        do_reset();

        check("rst_mem_resp",   {255'd0, mem_resp},   256'd0);
        check("rst_bmem_read",  {255'd0, bmem_read},  256'd0);
        check("rst_bmem_write", {255'd0, bmem_write}, 256'd0);
        check("rst_mem_rdata",  mem_rdata, 256'd0);
        check("rst_stats", {160'd0, stat_read_lines, stat_write_lines, stat_stall_cycles}, 256'd0);

        // Read with exact latency
        push_read(32'h1000_0020, line_a);
        mem_addr = 32'h1000_0024; mem_read = 1'b1;
        tick();
        check("rd_cmd_now", {255'd0, bmem_read}, 256'd1);
        tick();
        for (int k = 0; k < 4; k++) send_beat(32'h1000_0020, line_a[k*64 +: 64]);
        wait_resp("rd1_resp_latency", 1);
        check("rd1_stat_read", {224'd0, stat_read_lines}, 256'd1);

        // Write with two stall cycles before beat 2
        push_write(32'h2000_0040, line_w);
        mem_addr = 32'h2000_0040; mem_write = 1'b1; mem_wdata = line_w;
        tick();
        tick();
        tick();
        bmem_ready = 1'b0;
        check("wr_hold_c0", {192'd0, bmem_wdata}, {192'd0, line_w[128 +: 64]});
        tick();
        check("wr_hold_c1", {192'd0, bmem_wdata}, {192'd0, line_w[128 +: 64]});
        tick();
        bmem_ready = 1'b1;
        wait_resp("wr_resp", 3);
        check("wr_stat_write", {224'd0, stat_write_lines}, 256'd1);
        check("wr_stat_stall", {224'd0, stat_stall_cycles}, 256'd2);

        // Read with stray beat and rvalid gap
        push_read(32'h3000_0060, line_c);
        mem_addr = 32'h3000_0060; mem_read = 1'b1;
        tick();
        tick();
        send_beat(32'h3000_0060, line_c[0 +: 64]);
        send_beat(32'h3000_0000, 64'hBAD0_BAD0_BAD0_BAD0);
        send_beat(32'h3000_0060, line_c[64 +: 64]);
        tick(); tick(); tick();
        check("rd3_no_early_resp", {255'd0, mem_resp}, 256'd0);
        send_beat(32'h3000_0060, line_c[128 +: 64]);
        send_beat(32'h3000_0068, line_c[192 +: 64]);
        wait_resp("rd3_resp", 1);

        // Simultaneous read and write: write wins
        push_write(32'h4000_0080, line_d);
        mem_addr = 32'h4000_0080; mem_read = 1'b1; mem_write = 1'b1; mem_wdata = line_d;
        tick();
        check("both_no_read", {255'd0, bmem_read}, 256'd0);
        check("both_write",   {255'd0, bmem_write}, 256'd1);
        wait_resp("both_resp", 6);

        // Reset during a read burst
        cmd_q.push_back(32'h5000_00A0);
        mem_addr = 32'h5000_00A0; mem_read = 1'b1;
        tick();
        mem_read = 1'b0;
        tick();
        send_beat(32'h5000_00A0, 64'h5555_0000);
        send_beat(32'h5000_00A0, 64'h5555_0001);
        do_reset();
        send_beat(32'h5000_00A0, 64'h5555_0002);
        send_beat(32'h5000_00A0, 64'h5555_0003);
        tick();
        check("rst_mid_read_idle", {254'd0, bmem_read, bmem_write}, 256'd0);
        check("rst_mid_stat", {224'd0, stat_read_lines}, 256'd0);
        push_read(32'h5000_00A0, line_e);
        mem_read = 1'b1;
        tick();
        tick();
        for (int k = 0; k < 4; k++) send_beat(32'h5000_00A0, line_e[k*64 +: 64]);
        wait_resp("rd5_resp", 1);

        // Back-to-back reads with the request held through mem_resp
        do_reset();
        push_read(32'h6000_0000, line_f);
        push_read(32'h6000_0020, line_a);
        mem_addr = 32'h6000_0000; mem_read = 1'b1;
        tick();
        tick();
        for (int k = 0; k < 4; k++) send_beat(32'h6000_0000, line_f[k*64 +: 64]);
        check("b2b_resp1", {255'd0, mem_resp}, 256'd1);
        mem_addr = 32'h6000_0020;
        tick();
        check("b2b_idle_gap", {255'd0, bmem_read}, 256'd0);
        tick();
        check("b2b_cmd2", {255'd0, bmem_read}, 256'd1);
        tick();
        for (int k = 0; k < 4; k++) send_beat(32'h6000_0020, line_a[k*64 +: 64]);
        wait_resp("b2b_resp2", 1);
        check("b2b_stat_read", {224'd0, stat_read_lines}, 256'd2);

        tick();
        tick();
        check("left_resp", 256'(resp_q.size()), 256'd0);
        check("left_cmd",  256'(cmd_q.size()),  256'd0);
        check("left_wbeat", 256'(wb_q.size()),  256'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout act=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
